// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: captures precise exceptions, drives the
// flush/redirect handshake toward the front end, and returns from traps on mret.
module csr_trap_unit #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_1000
) (
   input  logic        clk_i,
   input  logic        rsn_i,
   input  logic        exc_occured_i,
   input  logic [31:0] exc_mtval_i,
   input  logic [31:0] exc_mepc_i,
   input  logic [31:0] exc_mcause_i,
   input  logic        mret_i,
   input  logic        csr_we_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic [31:0] csr_rdata_o,
   output logic        flush_o,
   output logic        stall_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic        mie_o
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_REDIRECT
   } state_e;

   state_e      state_q, state_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic        exc_take;
   logic        mret_take;
   logic        csr_wr;
   logic [31:0] trap_target;

   // Traps and mret are only honoured while idle; a CSR write colliding with an
   // accepted exception is discarded so software cannot corrupt the captured state.
   assign exc_take  = (state_q == ST_IDLE) && exc_occured_i;
   assign mret_take = (state_q == ST_IDLE) && mret_i && !exc_occured_i;
   assign csr_wr    = csr_we_i && !exc_take;

   always_comb begin
      trap_target = {mtvec_q[31:2], 2'b00};
      if (mtvec_q[0] && mcause_q[31]) begin
         trap_target = {mtvec_q[31:2], 2'b00} + {mcause_q[29:0], 2'b00};
      end
   end

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (exc_take) begin
               state_d = ST_FLUSH;
            end else if (mret_take) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = mepc_q;
            end
         end
         ST_FLUSH: begin
            state_d       = ST_REDIRECT;
            redirect_pc_d = trap_target;
         end
         ST_REDIRECT: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;

      if (exc_take) begin
         mepc_d   = exc_mepc_i & ~32'h3;
         mcause_d = exc_mcause_i;
         mtval_d  = exc_mtval_i;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_take) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end

      // A software write applied in the same cycle as an mret wins on mstatus.
      if (csr_wr) begin
         case (csr_addr_i)
            ADDR_MSTATUS: begin
               mie_d  = csr_wdata_i[3];
               mpie_d = csr_wdata_i[7];
            end
            ADDR_MTVEC:    mtvec_d    = csr_wdata_i;
            ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
            ADDR_MEPC:     mepc_d     = csr_wdata_i & ~32'h3;
            ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
            ADDR_MTVAL:    mtval_d    = csr_wdata_i;
            default: ;
         endcase
      end
   end

   always_comb begin
      csr_rdata_o = 32'h0;
      case (csr_addr_i)
         ADDR_MSTATUS:  csr_rdata_o = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
         ADDR_MTVEC:    csr_rdata_o = mtvec_q;
         ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
         ADDR_MEPC:     csr_rdata_o = mepc_q;
         ADDR_MCAUSE:   csr_rdata_o = mcause_q;
         ADDR_MTVAL:    csr_rdata_o = mtval_q;
         default:       csr_rdata_o = 32'h0;
      endcase
   end

   assign flush_o          = (state_q == ST_FLUSH);
   assign stall_o          = (state_q != ST_IDLE);
   assign redirect_valid_o = (state_q == ST_REDIRECT);
   assign redirect_pc_o    = redirect_pc_q;
   assign mie_o            = mie_q;

   // NOTE: state uses non-blocking assignments only; the small CSR set is reset
   // asynchronously so a mid-trap reset leaves nothing pending.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q       <= ST_IDLE;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         mtvec_q       <= MTVEC_RESET;
         mscratch_q    <= 32'h0;
         mepc_q        <= 32'h0;
         mcause_q      <= 32'h0;
         mtval_q       <= 32'h0;
         redirect_pc_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_csr_trap_unit;

   logic        clk_i = 1'b0;
   logic        rsn_i;
   logic        exc_occured_i;
   logic [31:0] exc_mtval_i, exc_mepc_i, exc_mcause_i;
   logic        mret_i;
   logic        csr_we_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;
   logic        flush_o, stall_o, redirect_valid_o, mie_o;
   logic [31:0] redirect_pc_o;

   always #5 clk_i = ~clk_i;

   csr_trap_unit dut (
      .clk_i            (clk_i),
      .rsn_i            (rsn_i),
      .exc_occured_i    (exc_occured_i),
      .exc_mtval_i      (exc_mtval_i),
      .exc_mepc_i       (exc_mepc_i),
      .exc_mcause_i     (exc_mcause_i),
      .mret_i           (mret_i),
      .csr_we_i         (csr_we_i),
      .csr_addr_i       (csr_addr_i),
      .csr_wdata_i      (csr_wdata_i),
      .csr_rdata_o      (csr_rdata_o),
      .flush_o          (flush_o),
      .stall_o          (stall_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .mie_o            (mie_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: architectural CSR values plus the number of handshake
   // cycles still owed to the front end (2 = flush next, 1 = redirect next).
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_pc;
   logic        m_mie, m_mpie;
   int          m_left;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_target(input logic [31:0] tvec, input logic [31:0] cause);
      logic [31:0] base;
      base = tvec & 32'hFFFF_FFFC;
      if (tvec[0] == 1'b1 && cause[31] == 1'b1) return base + (cause & 32'h7FFF_FFFF) * 4;
      return base;
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_mtvec = 32'h0000_1000; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_pc = 0; m_mie = 0; m_mpie = 0; m_left = 0;
   endtask

   task automatic model_step();
      logic take_exc, take_mret;
      if (!rsn_i) begin
         model_reset();
         return;
      end
      take_exc  = (m_left == 0) && exc_occured_i;
      take_mret = (m_left == 0) && mret_i && !exc_occured_i;
      if (m_left == 2) m_pc = m_target(m_mtvec, m_mcause);
      if (take_mret)   m_pc = m_mepc;
      if (m_left > 0)  m_left--;
      if (take_exc) begin
         m_left = 2;
         m_mepc = exc_mepc_i & 32'hFFFF_FFFC; m_mcause = exc_mcause_i; m_mtval = exc_mtval_i;
         m_mpie = m_mie; m_mie = 0;
      end
      if (take_mret) begin
         m_left = 1;
         m_mie = m_mpie; m_mpie = 1;
      end
      if (csr_we_i && !take_exc) begin
         case (csr_addr_i)
            12'h300: begin m_mie = csr_wdata_i[3]; m_mpie = csr_wdata_i[7]; end
            12'h305: m_mtvec    = csr_wdata_i;
            12'h340: m_mscratch = csr_wdata_i;
            12'h341: m_mepc     = csr_wdata_i & 32'hFFFF_FFFC;
            12'h342: m_mcause   = csr_wdata_i;
            12'h343: m_mtval    = csr_wdata_i;
            default: ;
         endcase
      end
   endtask

   always @(negedge clk_i) begin
      check("flush_o",          32'(flush_o),          32'(m_left == 2));
      check("stall_o",          32'(stall_o),          32'(m_left > 0));
      check("redirect_valid_o", 32'(redirect_valid_o), 32'(m_left == 1));
      check("redirect_pc_o",    redirect_pc_o,         m_pc);
      check("mie_o",            32'(mie_o),            32'(m_mie));
      check("csr_rdata_o",      csr_rdata_o,           m_read(csr_addr_i));
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
      model_step();
   endtask

   task automatic quiet();
      exc_occured_i = 0; mret_i = 0; csr_we_i = 0;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
      tick();
      csr_we_i = 0;
   endtask

   task automatic read_check(input string name, input logic [11:0] a, input logic [31:0] exp);
      quiet();
      csr_addr_i = a;
      #1;
      check(name, csr_rdata_o, exp);
      tick();
   endtask

   task automatic set_exc(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
      exc_occured_i = 1; exc_mepc_i = pc; exc_mcause_i = cause; exc_mtval_i = tval;
   endtask

   logic [11:0] addr_tab [8] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h7C0, 12'h000};

   initial begin
      rsn_i = 0; quiet();
      exc_mepc_i = 0; exc_mcause_i = 0; exc_mtval_i = 0;
      csr_addr_i = 12'h305; csr_wdata_i = 0;
      model_reset();
      tick(); tick();
      rsn_i = 1;
      tick();

      // Reset state
      check("reset_mtvec", csr_rdata_o, 32'h0000_1000);
      check("reset_stall", 32'(stall_o), 32'h0);
      check("reset_pc",    redirect_pc_o, 32'h0);

      // Direct trap
      csr_write(12'h300, 32'h8);
      set_exc(32'h80, 32'h2, 32'hDEAD);
      tick();
      quiet();
      check("trap_flush", 32'(flush_o), 32'h1);
      check("trap_stall", 32'(stall_o), 32'h1);
      tick();
      check("trap_redirect_valid", 32'(redirect_valid_o), 32'h1);
      check("trap_redirect_pc",    redirect_pc_o, 32'h1000);
      check("trap_no_flush",       32'(flush_o), 32'h0);
      tick();
      check("trap_mie_o", 32'(mie_o), 32'h0);
      read_check("trap_mepc",    12'h341, 32'h80);
      read_check("trap_mcause",  12'h342, 32'h2);
      read_check("trap_mtval",   12'h343, 32'hDEAD);
      read_check("trap_mstatus", 12'h300, 32'h80);

      // Vectored trap
      csr_write(12'h305, 32'h2001);
      set_exc(32'h300, 32'h8000_0007, 32'h0);
      tick();
      quiet();
      tick();
      check("vec_redirect_valid", 32'(redirect_valid_o), 32'h1);
      check("vec_redirect_pc",    redirect_pc_o, 32'h201C);
      tick();

      // mret
      csr_write(12'h341, 32'h84);
      csr_write(12'h300, 32'h80);
      mret_i = 1;
      tick();
      mret_i = 0;
      check("mret_redirect_valid", 32'(redirect_valid_o), 32'h1);
      check("mret_redirect_pc",    redirect_pc_o, 32'h84);
      check("mret_no_flush",       32'(flush_o), 32'h0);
      check("mret_mie_o",          32'(mie_o), 32'h1);
      tick();
      check("mret_done", 32'(stall_o), 32'h0);
      read_check("mret_mstatus", 12'h300, 32'h88);

      // Collision: exc + mret + CSR write, then a second exc during FLUSH
      csr_write(12'h340, 32'h11);
      set_exc(32'h100, 32'h5, 32'h77);
      mret_i = 1; csr_we_i = 1; csr_addr_i = 12'h340; csr_wdata_i = 32'h55;
      tick();
      quiet();
      check("coll_flush", 32'(flush_o), 32'h1);
      set_exc(32'h200, 32'h9, 32'h99);
      tick();
      quiet();
      check("coll_redirect_valid", 32'(redirect_valid_o), 32'h1);
      check("coll_redirect_pc",    redirect_pc_o, 32'h2000);
      tick();
      read_check("coll_mscratch", 12'h340, 32'h11);
      read_check("coll_mepc",     12'h341, 32'h100);
      read_check("coll_mcause",   12'h342, 32'h5);
      read_check("coll_mtval",    12'h343, 32'h77);

      // Reset during FLUSH
      set_exc(32'h40, 32'h3, 32'h1);
      tick();
      quiet();
      check("rst_in_flush", 32'(flush_o), 32'h1);
      rsn_i = 0;
      model_reset();
      csr_addr_i = 12'h305;
      #1;
      check("rst_flush",    32'(flush_o), 32'h0);
      check("rst_stall",    32'(stall_o), 32'h0);
      check("rst_redirect", 32'(redirect_valid_o), 32'h0);
      check("rst_pc",       redirect_pc_o, 32'h0);
      check("rst_mie",      32'(mie_o), 32'h0);
      check("rst_mtvec",    csr_rdata_o, 32'h1000);
      tick();
      rsn_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_no_redirect", 32'(redirect_valid_o), 32'h0);
      end

      // CSR access
      csr_write(12'h341, 32'hFFFF_FFFF);
      csr_write(12'h7C0, 32'hFFFF_FFFF);
      read_check("csr_mepc_align", 12'h341, 32'hFFFF_FFFC);
      read_check("csr_unmapped",   12'h7C0, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int idx;
         exc_occured_i = ($urandom_range(0, 7) == 0);
         mret_i        = ($urandom_range(0, 7) == 0);
         csr_we_i      = ($urandom_range(0, 2) == 0);
         idx           = $urandom_range(0, 7);
         csr_addr_i    = (idx == 7) ? 12'($urandom) : addr_tab[idx];
         csr_wdata_i   = $urandom;
         exc_mepc_i    = $urandom;
         exc_mcause_i  = $urandom;
         exc_mtval_i   = $urandom;
         if ($urandom_range(0, 149) == 0) begin
            rsn_i = 0;
            model_reset();
         end else begin
            rsn_i = 1;
         end
         tick();
      end
      quiet();
      rsn_i = 1;
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 The module SHALL have parameter MTVEC_RESET, default 32'h0000_1000, meaning the reset value of mtvec.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rsn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port exc_occured_i, input, 1 bit: single-cycle pulse marking a precise exception after history-file recovery completes.
REQ-005 The module SHALL have ports exc_mtval_i, exc_mepc_i and exc_mcause_i, each input, 32 bits: trap value, faulting PC and cause, valid with exc_occured_i.
REQ-006 The module SHALL have port mret_i, input, 1 bit: an mret has committed this cycle.
REQ-007 The module SHALL have ports csr_we_i (input, 1 bit), csr_addr_i (input, 12 bits) and csr_wdata_i (input, 32 bits): software CSR write.
REQ-008 The module SHALL have port csr_rdata_o, output, 32 bits: combinational read of the CSR at csr_addr_i.
REQ-009 The module SHALL have ports flush_o and stall_o, each output, 1 bit: pipeline flush and front-end stall.
REQ-010 The module SHALL have ports redirect_valid_o (output, 1 bit) and redirect_pc_o (output, 32 bits): fetch redirect.
REQ-011 The module SHALL have port mie_o, output, 1 bit: current mstatus.MIE.

Function
REQ-012 The module SHALL implement the following CSRs; any other address SHALL read 0 and ignore writes:
- mstatus 0x300 (only MIE bit3 and MPIE bit7 writable; other bits read 0)
- mtvec 0x305
- mscratch 0x340
- mepc 0x341 (bits[1:0] forced 0)
- mcause 0x342
- mtval 0x343
REQ-013 The module SHALL implement FSM states IDLE, FLUSH and REDIRECT.
REQ-014 In IDLE, an exc_occured_i pulse SHALL capture the following on the same edge, then go to FLUSH:
- mepc <= exc_mepc_i & ~3
- mcause <= exc_mcause_i
- mtval <= exc_mtval_i
- MPIE <= MIE; MIE <= 0
REQ-015 FLUSH SHALL assert flush_o=1 and stall_o=1 for exactly one cycle, then go to REDIRECT.
REQ-016 REDIRECT SHALL assert redirect_valid_o=1 and stall_o=1 for exactly one cycle, then return to IDLE.
REQ-017 The trap target SHALL be computed as follows (32-bit wrap-around on the add):
- mtvec[0]=1 and mcause[31]=1: (mtvec & ~3) + (mcause[30:0] << 2)
- otherwise: mtvec & ~3
REQ-018 In IDLE, mret_i without exc_occured_i SHALL:
- set MIE <= MPIE and MPIE <= 1
- go to REDIRECT with target mepc, without passing through FLUSH
REQ-019 Simultaneous exc_occured_i and mret_i SHALL take the exception path; mret_i is dropped.
REQ-020 exc_occured_i or mret_i arriving in FLUSH or REDIRECT SHALL be ignored.
REQ-021 A csr_we_i in the same cycle as an accepted exc_occured_i SHALL be dropped entirely; otherwise csr_we_i SHALL be accepted in any state.
REQ-022 csr_rdata_o SHALL reflect register contents before the current edge, with no write bypass.
REQ-023 redirect_pc_o SHALL hold its last value when redirect_valid_o=0.

Reset
REQ-024 While rsn_i=0, the module SHALL force the following regardless of clock:
- state = IDLE
- mtvec = MTVEC_RESET
- all other CSRs = 0
- flush_o, stall_o, redirect_valid_o, mie_o = 0
- redirect_pc_o = 0
REQ-025 Reset asserted mid-trap (FLUSH or REDIRECT) SHALL abort the sequence with no redirect issued after release.

Verification
REQ-026 The bench SHALL cover a direct trap:
- stimulus: MIE=1, exc pulse with mepc=0x80, mcause=2, mtval=0xDEAD
- response: next cycle flush_o=1; cycle after, redirect_valid_o=1 with pc=0x1000; mepc=0x80, mcause=2, mtval=0xDEAD, MIE=0, MPIE=1
REQ-027 The bench SHALL cover a vectored trap:
- stimulus: mtvec=0x2001, exc with mcause=0x8000_0007
- response: redirect pc=0x201C
REQ-028 The bench SHALL cover mret:
- stimulus: mepc=0x84, MPIE=1, mret_i pulse
- response: next cycle redirect_valid_o=1 with pc=0x84; MIE=1; flush_o stays 0
REQ-029 The bench SHALL cover a collision:
- stimulus: exc and mret_i in the same cycle, plus csr_we_i to mscratch with 0x55
- response: exception path taken; mscratch unchanged
- stimulus: a second exc during FLUSH
- response: ignored; CSRs keep first values
REQ-030 The bench SHALL cover reset mid-trap:
- stimulus: rsn_i=0 during FLUSH
- response: outputs 0 immediately; mtvec=0x1000; no redirect after release
REQ-031 The bench SHALL cover CSR access:
- stimulus: write 0xFFFF_FFFF to mepc, then to 0x7C0
- response: mepc reads 0xFFFF_FFFC; 0x7C0 reads 0
